sphere_job_dispatcher: RTL and testbench

Host-side driver for the sphere–sphere collision core. It accepts one collision job from the CPU link as a stream of ten 32-bit words and holds those operands stable on the core's operand ports. It then pulses the core's active-low start/reset and waits for the core's `done`, with a timeout. Finally it captures the contact result and streams it back to the CPU as a ten-word record. The dispatcher sits between the CPU–FPGA bridge and one collision core instance; the core is external and wired through the `core_*` ports.

---
 rtl/sphere_job_pkg.sv | 61 ++++++
 rtl/sync_2ff.sv | 30 +++
 rtl/sphere_job_dispatcher.sv | 185 ++++++++++++++++++
 tb/tb_sphere_job_dispatcher.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sphere_job_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sphere_job_pkg
// Description : Shared types and constants for the sphere collision job
//               dispatcher (FSM states, word indices, status layout).
// Revision    : 1.0 - initial release
// ============================================================================
package sphere_job_pkg;

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_START   = 3'd1,
        S_RUN     = 3'd2,
        S_CAPTURE = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    localparam int JOB_WORDS = 10;
    localparam int RES_WORDS = 10;

    localparam int ST_RET     = 0;
    localparam int ST_TIMEOUT = 1;
    localparam int ST_TAG_LSB = 8;

    // Job word order as sent by the host
    localparam logic [3:0] IDX_X1 = 4'd0;
    localparam logic [3:0] IDX_Y1 = 4'd1;
    localparam logic [3:0] IDX_Z1 = 4'd2;
    localparam logic [3:0] IDX_R1 = 4'd3;
    localparam logic [3:0] IDX_X2 = 4'd4;
    localparam logic [3:0] IDX_Y2 = 4'd5;
    localparam logic [3:0] IDX_Z2 = 4'd6;
    localparam logic [3:0] IDX_R2 = 4'd7;
    localparam logic [3:0] IDX_G1 = 4'd8;
    localparam logic [3:0] IDX_G2 = 4'd9;

    // Result record order as returned to the host
    localparam logic [3:0] RES_STATUS = 4'd0;
    localparam logic [3:0] RES_CX     = 4'd1;
    localparam logic [3:0] RES_CY     = 4'd2;
    localparam logic [3:0] RES_CZ     = 4'd3;
    localparam logic [3:0] RES_NX     = 4'd4;
    localparam logic [3:0] RES_NY     = 4'd5;
    localparam logic [3:0] RES_NZ     = 4'd6;
    localparam logic [3:0] RES_DEPTH  = 4'd7;
    localparam logic [3:0] RES_G1     = 4'd8;
    localparam logic [3:0] RES_G2     = 4'd9;

    function automatic logic [31:0] make_status(input logic [7:0] tag,
                                                input logic       timeout,
                                                input logic       ret);
        logic [31:0] s;
        s                   = '0;
        s[ST_RET]           = ret;
        s[ST_TIMEOUT]       = timeout;
        s[ST_TAG_LSB +: 8]  = tag;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : 1-bit two-flop synchroniser, asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/sphere_job_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : sphere_job_dispatcher
// Description : Loads a 10-word collision job, runs the external sphere core
//               with timeout, and streams back a 10-word contact record.
// Revision    : 1.0 - initial release
// ============================================================================
module sphere_job_dispatcher
    import sphere_job_pkg::*;
#(
    parameter int RST_HOLD       = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        busy,
    output logic [31:0] core_x1,
    output logic [31:0] core_y1,
    output logic [31:0] core_z1,
    output logic [31:0] core_r1,
    output logic [31:0] core_x2,
    output logic [31:0] core_y2,
    output logic [31:0] core_z2,
    output logic [31:0] core_r2,
    output logic [31:0] core_g1,
    output logic [31:0] core_g2,
    output logic        core_rst,
    input  logic        core_done,
    input  logic        core_ret,
    input  logic [31:0] core_cx,
    input  logic [31:0] core_cy,
    input  logic [31:0] core_cz,
    input  logic [31:0] core_nx,
    input  logic [31:0] core_ny,
    input  logic [31:0] core_nz,
    input  logic [31:0] core_depth
);

    // One counter serves both the START hold and the RUN timeout
    localparam int c_CNT_MAX = (TIMEOUT_CYCLES > RST_HOLD) ? TIMEOUT_CYCLES : RST_HOLD;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(RST_HOLD - 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST   = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] c_JOB_LAST = 4'(JOB_WORDS - 1);
    localparam logic [3:0] c_RES_LAST = 4'(RES_WORDS - 1);

    state_t                        r_state;
    logic [3:0]                    r_idx;
    logic [3:0]                    r_ridx;
    logic [7:0]                    r_tag;
    logic [c_CNT_W-1:0]            r_cnt;
    logic                          r_core_rst;
    logic                          r_timeout;
    logic                          r_ret;
    logic [JOB_WORDS-1:0][31:0]    r_ops;
    logic [6:0][31:0]              r_contact;
    logic                          w_done_s;
    logic [31:0]                   w_rd_data;

    sync_2ff u_done_sync (
        .clk (clk),
        .rst (rst),
        .i_d (core_done),
        .o_q (w_done_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_LOAD;
            r_idx      <= '0;
            r_ridx     <= '0;
            r_tag      <= '0;
            r_cnt      <= '0;
            r_core_rst <= 1'b0;
            r_timeout  <= 1'b0;
            r_ret      <= 1'b0;
            r_ops      <= '0;
            r_contact  <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (wr_valid) begin
                        r_ops[r_idx] <= wr_data;
                        if (r_idx == c_JOB_LAST) begin
                            r_idx   <= '0;
                            r_cnt   <= '0;
                            r_state <= S_START;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                S_START: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        r_cnt      <= '0;
                        r_core_rst <= 1'b1;
                        r_state    <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_RUN: begin
                    // A done arriving on the timeout cycle still counts as done
                    if (w_done_s) begin
                        r_timeout <= 1'b0;
                        r_state   <= S_CAPTURE;
                    end else if (r_cnt == c_TO_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    r_ret        <= core_ret & ~r_timeout;
                    r_contact[0] <= r_timeout ? '0 : core_cx;
                    r_contact[1] <= r_timeout ? '0 : core_cy;
                    r_contact[2] <= r_timeout ? '0 : core_cz;
                    r_contact[3] <= r_timeout ? '0 : core_nx;
                    r_contact[4] <= r_timeout ? '0 : core_ny;
                    r_contact[5] <= r_timeout ? '0 : core_nz;
                    r_contact[6] <= r_timeout ? '0 : core_depth;
                    r_state      <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (rd_ready) begin
                        if (r_ridx == c_RES_LAST) begin
                            r_ridx     <= '0;
                            r_tag      <= r_tag + 8'd1;
                            r_core_rst <= 1'b0;
                            r_state    <= S_LOAD;
                        end else begin
                            r_ridx <= r_ridx + 4'd1;
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    always_comb begin
        w_rd_data = '0;
        if (r_state == S_DRAIN) begin
            case (r_ridx)
                RES_STATUS: w_rd_data = make_status(r_tag, r_timeout, r_ret);
                RES_CX:     w_rd_data = r_contact[0];
                RES_CY:     w_rd_data = r_contact[1];
                RES_CZ:     w_rd_data = r_contact[2];
                RES_NX:     w_rd_data = r_contact[3];
                RES_NY:     w_rd_data = r_contact[4];
                RES_NZ:     w_rd_data = r_contact[5];
                RES_DEPTH:  w_rd_data = r_contact[6];
                RES_G1:     w_rd_data = r_ops[IDX_G1];
                RES_G2:     w_rd_data = r_ops[IDX_G2];
                default:    w_rd_data = '0;
            endcase
        end
    end

    assign wr_ready = (r_state == S_LOAD);
    assign rd_valid = (r_state == S_DRAIN);
    assign busy     = (r_state != S_LOAD) || (r_idx != 4'd0);
    assign rd_data  = w_rd_data;
    assign core_rst = r_core_rst;

    assign core_x1 = r_ops[IDX_X1];
    assign core_y1 = r_ops[IDX_Y1];
    assign core_z1 = r_ops[IDX_Z1];
    assign core_r1 = r_ops[IDX_R1];
    assign core_x2 = r_ops[IDX_X2];
    assign core_y2 = r_ops[IDX_Y2];
    assign core_z2 = r_ops[IDX_Z2];
    assign core_r2 = r_ops[IDX_R2];
    assign core_g1 = r_ops[IDX_G1];
    assign core_g2 = r_ops[IDX_G2];

endmodule
`default_nettype wire

// File: tb/tb_sphere_job_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_sphere_job_dispatcher
// Description : Self-checking bench for sphere_job_dispatcher with a
//               behavioural core stub and an expected-record scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sphere_job_dispatcher;

    localparam int RST_HOLD = 2;
    localparam int TO       = 64;

    logic        clk;
    logic        rst;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        busy;
    logic [31:0] core_x1, core_y1, core_z1, core_r1;
    logic [31:0] core_x2, core_y2, core_z2, core_r2;
    logic [31:0] core_g1, core_g2;
    logic        core_rst;
    logic        core_done;
    logic        core_ret;
    logic [31:0] core_cx, core_cy, core_cz, core_nx, core_ny, core_nz, core_depth;

    logic [31:0] job_ops   [10];
    logic [31:0] stub_vals [7];
    logic        stub_ret;
    int          stub_delay;
    int          stub_cnt;
    int          exp_tag;
    logic [31:0] exp_q [$];
    int          n_chk;
    int          n_pass;
    int          n_fail;

    sphere_job_dispatcher #(
        .RST_HOLD       (RST_HOLD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .busy       (busy),
        .core_x1    (core_x1),
        .core_y1    (core_y1),
        .core_z1    (core_z1),
        .core_r1    (core_r1),
        .core_x2    (core_x2),
        .core_y2    (core_y2),
        .core_z2    (core_z2),
        .core_r2    (core_r2),
        .core_g1    (core_g1),
        .core_g2    (core_g2),
        .core_rst   (core_rst),
        .core_done  (core_done),
        .core_ret   (core_ret),
        .core_cx    (core_cx),
        .core_cy    (core_cy),
        .core_cz    (core_cz),
        .core_nx    (core_nx),
        .core_ny    (core_ny),
        .core_nz    (core_nz),
        .core_depth (core_depth)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Core stub: raises done stub_delay+1 edges after it first sees core_rst high
    always @(posedge clk) begin
        if (core_rst !== 1'b1) begin
            stub_cnt  <= 0;
            core_done <= 1'b0;
        end else begin
            stub_cnt <= stub_cnt + 1;
            if (stub_delay >= 0 && stub_cnt == stub_delay)
                core_done <= 1'b1;
        end
    end

    assign core_ret   = stub_ret;
    assign core_cx    = stub_vals[0];
    assign core_cy    = stub_vals[1];
    assign core_cz    = stub_vals[2];
    assign core_nx    = stub_vals[3];
    assign core_ny    = stub_vals[4];
    assign core_nz    = stub_vals[5];
    assign core_depth = stub_vals[6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic predict_timeout();
        // done_s lands exactly on the timeout cycle when stub_delay == TO-4
        return (stub_delay < 0) || (stub_delay > TO - 4);
    endfunction

    task automatic send_job();
        logic to;
        to = predict_timeout();
        exp_q.push_back({16'h0, exp_tag[7:0], 6'h0, to, to ? 1'b0 : stub_ret});
        for (int i = 0; i < 7; i++) exp_q.push_back(to ? 32'h0 : stub_vals[i]);
        exp_q.push_back(job_ops[8]);
        exp_q.push_back(job_ops[9]);
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1;
            wr_data  = job_ops[i];
            tick();
        end
        wr_valid = 1'b0;
        wr_data  = '0;
    endtask

    task automatic chk_ops();
        chk("op_x1", core_x1, job_ops[0]);
        chk("op_y1", core_y1, job_ops[1]);
        chk("op_z1", core_z1, job_ops[2]);
        chk("op_r1", core_r1, job_ops[3]);
        chk("op_x2", core_x2, job_ops[4]);
        chk("op_y2", core_y2, job_ops[5]);
        chk("op_z2", core_z2, job_ops[6]);
        chk("op_r2", core_r2, job_ops[7]);
        chk("op_g1", core_g1, job_ops[8]);
        chk("op_g2", core_g2, job_ops[9]);
    endtask

    task automatic drain(input bit bp);
        int          got;
        int          guard;
        bit          holding;
        bit          wr_ok;
        logic [31:0] held;
        logic [31:0] exp;
        got = 0; guard = 0; holding = 1'b0; wr_ok = 1'b1; held = '0;
        while (got < 10 && guard < 300) begin
            rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (wr_ready !== 1'b0) wr_ok = 1'b0;
            if (holding && rd_valid === 1'b1) chk("rd_hold_stable", rd_data, held);
            if (rd_valid === 1'b1) begin
                if (rd_ready) begin
                    exp = exp_q.pop_front();
                    chk($sformatf("rd_word%0d", got), rd_data, exp);
                    got++;
                    holding = 1'b0;
                end else begin
                    held    = rd_data;
                    holding = 1'b1;
                end
            end
            tick();
            guard++;
        end
        rd_ready = 1'b0;
        chk("drain_count", got, 10);
        chk("wr_ready_low_during_drain", {31'h0, wr_ok}, 32'h1);
        chk("wr_ready_after_drain", {31'h0, wr_ready}, 32'h1);
        chk("core_rst_after_drain", {31'h0, core_rst}, 32'h0);
        chk("rd_valid_after_drain", {31'h0, rd_valid}, 32'h0);
        exp_q.delete();
        exp_tag = (exp_tag + 1) % 256;
    endtask

    task automatic run_job(input bit bp);
        int n;
        int exp_lat;
        exp_lat = predict_timeout() ? TO + 1 : stub_delay + 5;
        send_job();
        chk("busy_after_load", {31'h0, busy}, 32'h1);
        chk("wr_ready_after_load", {31'h0, wr_ready}, 32'h0);
        n = 0;
        while (core_rst !== 1'b1 && n < 50) begin tick(); n++; end
        chk("rst_hold_latency", n, RST_HOLD);
        chk_ops();
        n = 0;
        while (rd_valid !== 1'b1 && n < 500) begin tick(); n++; end
        chk("run_to_rd_valid_latency", n, exp_lat);
        drain(bp);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        n_chk = 0; n_pass = 0; n_fail = 0;
        rst = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        stub_delay = -1; stub_ret = 1'b0; exp_tag = 0;
        for (int i = 0; i < 7; i++) stub_vals[i] = '0;
        for (int i = 0; i < 10; i++) job_ops[i] = '0;
        tick(); tick();

        chk("reset_wr_ready", {31'h0, wr_ready}, 32'h1);
        chk("reset_rd_valid", {31'h0, rd_valid}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_core_rst", {31'h0, core_rst}, 32'h0);
        chk("reset_core_x1", core_x1, 32'h0);
        chk("reset_core_g2", core_g2, 32'h0);
        rst = 1'b1;
        tick();

        // Overlapping spheres
        job_ops = '{32'h0, 32'h0, 32'h0, 32'h3F800000, 32'h3FC00000,
                    32'h0, 32'h0, 32'h3F800000, 32'hA5A50001, 32'hDEADBEEF};
        stub_ret   = 1'b1;
        stub_vals  = '{32'h3F400000, 32'h0, 32'h0, 32'hBF800000, 32'h0, 32'h0, 32'h3F000000};
        stub_delay = 3;
        run_job(1'b0);

        // Separated spheres, tag 1, with read backpressure
        job_ops = '{32'h0, 32'h0, 32'h0, 32'h3F800000, 32'h40400000,
                    32'h0, 32'h0, 32'h3F800000, 32'h12345678, 32'h9ABCDEF0};
        stub_ret   = 1'b0;
        stub_vals  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        stub_delay = 5;
        run_job(1'b1);

        // Core never finishes; stub drives junk that must not be captured
        for (int i = 0; i < 10; i++) job_ops[i] = $urandom;
        stub_ret   = 1'b1;
        stub_vals  = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                       32'h55555555, 32'h66666666, 32'h77777777};
        stub_delay = -1;
        run_job(1'b1);

        // Reset in the middle of RUN
        for (int i = 0; i < 10; i++) job_ops[i] = 32'h10000000 + i + 1;
        stub_delay = -1;
        send_job();
        exp_q.delete();
        n = 0;
        while (core_rst !== 1'b1 && n < 50) begin tick(); n++; end
        chk("rst_hold_latency_mid", n, RST_HOLD);
        repeat (5) tick();
        rst = 1'b0;
        #1;
        chk("midrst_core_rst", {31'h0, core_rst}, 32'h0);
        chk("midrst_rd_valid", {31'h0, rd_valid}, 32'h0);
        chk("midrst_wr_ready", {31'h0, wr_ready}, 32'h1);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_core_x1", core_x1, 32'h0);
        repeat (3) begin
            tick();
            chk("midrst_hold_core_rst", {31'h0, core_rst}, 32'h0);
            chk("midrst_hold_rd_valid", {31'h0, rd_valid}, 32'h0);
        end
        rst = 1'b1;
        exp_tag = 0;
        tick();
        chk("postrst_wr_ready", {31'h0, wr_ready}, 32'h1);
        chk("postrst_core_rst", {31'h0, core_rst}, 32'h0);
        chk("postrst_rd_valid", {31'h0, rd_valid}, 32'h0);

        stub_ret   = 1'b1;
        stub_vals  = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE, 32'hF, 32'h10};
        stub_delay = 2;
        run_job(1'b0);

        // 257 jobs: tag wraps 255 -> 0; one job has done_s on the timeout cycle
        for (int k = 0; k < 257; k++) begin
            for (int i = 0; i < 10; i++) job_ops[i] = $urandom;
            for (int i = 0; i < 7; i++) stub_vals[i] = $urandom;
            stub_ret   = 1'($urandom_range(0, 1));
            stub_delay = (k == 100) ? TO - 4 : (k % 4);
            run_job(k % 3 == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
